// File: rtl/fp_div_pkg.sv
// Shared types and constants for the binary32 divider.
// Holds the FSM state enum, operand classes and the leading-zero helper.
package fp_div_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int ITER_N   = 26;
   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef enum logic [1:0] {
      IDLE,
      UNPACK,
      ITER,
      PACK
   } state_t;

   typedef enum logic [2:0] {
      ZERO,
      SUB,
      NORM,
      INF,
      NAN
   } fp_class_t;

   function automatic fp_class_t classify(input logic [31:0] x);
      fp_class_t c;
      if (x[30:23] == 8'h00)
         c = (x[22:0] == 23'd0) ? ZERO : SUB;
      else if (x[30:23] == 8'hFF)
         c = (x[22:0] == 23'd0) ? INF : NAN;
      else
         c = NORM;
      return c;
   endfunction

   // Highest set bit wins because the loop runs upward.
   function automatic logic [4:0] lzc24(input logic [23:0] v);
      logic [4:0] n;
      n = 5'd24;
      for (int i = 0; i < 24; i++)
         if (v[i]) n = 5'(23 - i);
      return n;
   endfunction

endpackage

// File: rtl/fp_div_mant_iter.sv
// 24-bit restoring mantissa divider producing 26 quotient bits.
// Ports: clk, rst, load, dividend, divisor -> quotient, sticky, valid.
module fp_div_mant_iter
   import fp_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [23:0] dividend,
   input  logic [23:0] divisor,
   output logic [25:0] quotient,
   output logic        sticky,
   output logic        valid
);

   logic [24:0] r_rem;
   logic [23:0] r_div;
   logic [25:0] r_q;
   logic [4:0]  r_cnt;
   logic        r_act;

   logic        w_ge;
   logic [23:0] w_diff;
   logic [23:0] w_keep;

   // Partial remainder stays below 2*divisor, so the
   // difference always fits back into 24 bits.
   assign w_ge   = r_rem >= {1'b0, r_div};
   assign w_diff = r_rem[23:0] - r_div;
   assign w_keep = w_ge ? w_diff : r_rem[23:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem <= '0;
         r_div <= '0;
         r_q   <= '0;
         r_cnt <= '0;
         r_act <= 1'b0;
      end else if (load) begin
         r_rem <= {1'b0, dividend};
         r_div <= divisor;
         r_q   <= '0;
         r_cnt <= 5'(ITER_N);
         r_act <= 1'b1;
      end else if (r_cnt != 5'd0) begin
         r_rem <= {w_keep, 1'b0};
         r_q   <= {r_q[24:0], w_ge};
         r_cnt <= r_cnt - 5'd1;
      end
   end

   assign quotient = r_q;
   assign sticky   = (r_rem != 25'd0);
   assign valid    = r_act & (r_cnt == 5'd0);

endmodule

// File: rtl/fp32_divider.sv
// IEEE-754 binary32 divider m = a / b, RNE, fixed 28-cycle latency.
// Ports: clk, rst, start, a, b -> busy, done, m, overflow, underflow.
// Define FP_DIV_DENORM_EN for subnormal support; otherwise flush-to-zero.
module fp32_divider
   import fp_div_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] m,
   output logic                  overflow,
   output logic                  underflow
);

   state_t r_state, w_state_nx;
   logic   w_load;

   logic [31:0]       r_a, r_b;
   logic              r_sign;
   logic signed [9:0] r_exp;
   logic              r_spec;
   logic [31:0]       r_spec_m;
   logic              r_spec_ovf;
   logic [4:0]        r_cnt;
   logic              r_done;
   logic [31:0]       r_m;
   logic              r_ovf;
   logic              r_unf;

   fp_class_t         w_ca, w_cb;
   logic [23:0]       w_ma, w_mb;
   logic signed [9:0] w_ea, w_eb, w_exp;
   logic              w_sign;
   logic              w_spec;
   logic [31:0]       w_spec_m;
   logic              w_spec_ovf;

   logic [25:0]       w_q;
   logic              w_sticky;
   logic              w_valid;

   logic [23:0]       w_man;
   logic              w_g, w_s, w_inc;
   logic signed [9:0] w_e, w_e_r;
   logic [24:0]       w_man_r;
   logic [31:0]       w_m;
   logic              w_ovf, w_unf;

`ifdef FP_DIV_DENORM_EN
   logic [4:0]        w_lza, w_lzb;
   logic signed [9:0] w_sh;
   logic [4:0]        w_shc;
   logic [25:0]       w_ext, w_shf, w_mask;
   logic              w_g2, w_s2;
   logic [23:0]       w_res;

   assign w_lza = lzc24({1'b0, r_a[22:0]});
   assign w_lzb = lzc24({1'b0, r_b[22:0]});
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_load     = 1'b0;
      case (r_state)
         IDLE:    if (start) w_state_nx = UNPACK;
         UNPACK: begin
            w_state_nx = ITER;
            w_load     = 1'b1;
         end
         ITER:    if (r_cnt == 5'd0) w_state_nx = PACK;
         PACK:    w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // ---------------- unpack ----------------
   always_comb begin
      w_ca = classify(r_a);
      w_cb = classify(r_b);
      w_ma = {1'b1, r_a[22:0]};
      w_mb = {1'b1, r_b[22:0]};
      w_ea = $signed({2'b00, r_a[30:23]});
      w_eb = $signed({2'b00, r_b[30:23]});
`ifdef FP_DIV_DENORM_EN
      // Normalise subnormals: shift the leading one up to bit 23.
      if (w_ca == SUB) begin
         w_ma = {1'b0, r_a[22:0]} << w_lza;
         w_ea = 10'sd1 - $signed({5'b0, w_lza});
      end
      if (w_cb == SUB) begin
         w_mb = {1'b0, r_b[22:0]} << w_lzb;
         w_eb = 10'sd1 - $signed({5'b0, w_lzb});
      end
`else
      if (w_ca == SUB) w_ca = ZERO;
      if (w_cb == SUB) w_cb = ZERO;
`endif
   end

   assign w_sign = r_a[31] ^ r_b[31];
   assign w_exp  = w_ea - w_eb + 10'(EXP_BIAS);

   always_comb begin
      w_spec     = 1'b1;
      w_spec_m   = '0;
      w_spec_ovf = 1'b0;
      if (w_ca == NAN || w_cb == NAN ||
          (w_ca == ZERO && w_cb == ZERO) ||
          (w_ca == INF && w_cb == INF))
         w_spec_m = QNAN;
      else if (w_ca == INF)
         w_spec_m = {w_sign, 8'hFF, 23'd0};
      else if (w_cb == INF)
         w_spec_m = {w_sign, 31'd0};
      else if (w_cb == ZERO) begin
         w_spec_m   = {w_sign, 8'hFF, 23'd0};
         w_spec_ovf = 1'b1;
      end else if (w_ca == ZERO)
         w_spec_m = {w_sign, 31'd0};
      else
         w_spec = 1'b0;
   end

   // ---------------- mantissa divider ----------------
   fp_div_mant_iter u_iter (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .dividend (w_ma),
      .divisor  (w_mb),
      .quotient (w_q),
      .sticky   (w_sticky),
      .valid    (w_valid)
   );

   // ---------------- normalise / round / pack ----------------
   always_comb begin
      w_inc   = 1'b0;
      w_man_r = '0;
      w_e_r   = '0;
      w_m     = '0;
      w_ovf   = 1'b0;
      w_unf   = 1'b0;
      // Quotient lies in (0.5, 2): at most one leading zero.
      if (w_q[25]) begin
         w_man = w_q[25:2];
         w_g   = w_q[1];
         w_s   = w_q[0] | w_sticky;
         w_e   = r_exp;
      end else begin
         w_man = w_q[24:1];
         w_g   = w_q[0];
         w_s   = w_sticky;
         w_e   = r_exp - 10'sd1;
      end
`ifdef FP_DIV_DENORM_EN
      w_sh   = '0;
      w_shc  = '0;
      w_ext  = '0;
      w_shf  = '0;
      w_mask = '0;
      w_g2   = 1'b0;
      w_s2   = 1'b0;
      w_res  = '0;
`endif
      if (w_e > 10'sd0) begin
         w_inc   = w_g & (w_s | w_man[0]);
         w_man_r = {1'b0, w_man} + {24'd0, w_inc};
         w_e_r   = w_e + $signed({9'd0, w_man_r[24]});
         if (w_e_r >= 10'sd255) begin
            w_m   = {r_sign, 8'hFF, 23'd0};
            w_ovf = 1'b1;
         end else begin
            w_m = {r_sign, w_e_r[7:0],
                   w_man_r[24] ? w_man_r[23:1] : w_man_r[22:0]};
         end
      end else begin
`ifdef FP_DIV_DENORM_EN
         // Denormalise; anything shifted past guard folds into sticky.
         w_sh   = 10'sd1 - w_e;
         w_shc  = (w_sh > 10'sd26) ? 5'd27 : w_sh[4:0];
         w_ext  = {w_man, w_g, w_s};
         w_shf  = w_ext >> w_shc;
         w_mask = (26'd1 << w_shc) - 26'd1;
         w_g2   = w_shf[1];
         w_s2   = w_shf[0] | (|(w_ext & w_mask));
         w_res  = w_shf[25:2] +
                  {23'd0, w_g2 & (w_s2 | w_shf[2])};
         // A carry into bit 23 lands in the exponent LSB.
         w_m    = {r_sign, 7'd0, w_res};
         w_unf  = w_g2 | w_s2;
`else
         w_m   = {r_sign, 31'd0};
         w_unf = 1'b1;
`endif
      end
      if (r_spec) begin
         w_m   = r_spec_m;
         w_ovf = r_spec_ovf;
         w_unf = 1'b0;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_sign     <= 1'b0;
         r_exp      <= '0;
         r_spec     <= 1'b0;
         r_spec_m   <= '0;
         r_spec_ovf <= 1'b0;
         r_cnt      <= '0;
         r_done     <= 1'b0;
         r_m        <= '0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               r_a <= a[31:0];
               r_b <= b[31:0];
            end
            UNPACK: begin
               r_sign     <= w_sign;
               r_exp      <= w_exp;
               r_spec     <= w_spec;
               r_spec_m   <= w_spec_m;
               r_spec_ovf <= w_spec_ovf;
               r_cnt      <= 5'(ITER_N - 1);
            end
            ITER: if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
            PACK: if (w_valid) begin
               r_done <= 1'b1;
               r_m    <= w_m;
               r_ovf  <= w_ovf;
               r_unf  <= w_unf;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (r_state != IDLE);
   assign done      = r_done;
   assign m         = r_m;
   assign overflow  = r_ovf;
   assign underflow = r_unf;

endmodule

// File: tb/tb_fp32_divider.sv
// Directed self-checking bench for fp32_divider.
// Expected values are hand-computed binary32 results.
module tb_fp32_divider;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] m;
   logic        overflow, underflow;

   int total = 0;
   int bad   = 0;
   int lat;
   int ndone;

`ifdef FP_DIV_DENORM_EN
   localparam logic [31:0] EXP_SUBIN  = 32'h00A60DD6;
   localparam logic [31:0] EXP_TINY   = 32'h00400000;
   localparam logic [31:0] EXP_TINY_U = 32'd0;
`else
   localparam logic [31:0] EXP_SUBIN  = 32'h00000000;
   localparam logic [31:0] EXP_TINY   = 32'h00000000;
   localparam logic [31:0] EXP_TINY_U = 32'd1;
`endif

   fp32_divider #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .m         (m),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic run(input logic [31:0] ia, input logic [31:0] ib,
                      output int n);
      @(negedge clk);
      a     = ia;
      b     = ib;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (done) break;
      end
   endtask

   task automatic vec(input string tag, input logic [31:0] ia,
                      input logic [31:0] ib, input logic [31:0] em,
                      input logic eo, input logic eu);
      int n;
      run(ia, ib, n);
      chk({tag, "_lat"}, 32'(n), 32'd28);
      chk({tag, "_m"}, m, em);
      chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
      chk({tag, "_unf"}, {31'd0, underflow}, {31'd0, eu});
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_m", m, 32'd0);
      chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // finite / inf, with latency and pulse width
      run(32'h38140000, 32'h7F800000, lat);
      chk("finf_lat", 32'(lat), 32'd28);
      chk("finf_m", m, 32'h00000000);
      chk("finf_flags", {30'd0, overflow, underflow}, 32'd0);
      @(posedge clk);
      #1;
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("m_hold", m, 32'h00000000);

      vec("divzero", 32'h4FF00800, 32'h00000000, 32'h7F800000, 1'b1, 1'b0);
      vec("subin", 32'h00000180, 32'h38140000, EXP_SUBIN, 1'b0, 1'b0);
      vec("nan", 32'h38140000, 32'h7F818000, 32'h7FC00000, 1'b0, 1'b0);
      vec("inff", 32'h7F800000, 32'h38140000, 32'h7F800000, 1'b0, 1'b0);
      vec("3div2", 32'h40400000, 32'h40000000, 32'h3FC00000, 1'b0, 1'b0);
      vec("1div3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0);
      vec("neg6div2", 32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0);
      vec("ovf", 32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b1, 1'b0);
      vec("tiny", 32'h00800000, 32'h40000000, EXP_TINY, 1'b0, EXP_TINY_U[0]);
      vec("zz", 32'h00000000, 32'h80000000, 32'h7FC00000, 1'b0, 1'b0);
      vec("negzero", 32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1'b0);

      // start held high for 20 cycles: only one operation
      @(negedge clk);
      a     = 32'h40400000;
      b     = 32'h40000000;
      start = 1'b1;
      ndone = 0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
         if (i == 19) start = 1'b0;
      end
      chk("hold_ndone", 32'(ndone), 32'd1);
      chk("hold_m", m, 32'h3FC00000);

      // leave flags set, then abort mid-iteration
      vec("ovf2", 32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b1, 1'b0);
      @(negedge clk);
      a     = 32'h3F800000;
      b     = 32'h40400000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_m", m, 32'd0);
      chk("abort_flags", {30'd0, overflow, underflow}, 32'd0);
      @(negedge clk);
      rst   = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("abort_ndone", 32'(ndone), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
